// File: rtl/cbus_resp_pkg.sv
// Shared types for the CBus SRAM responder: FSM states, counter widths and
// the request/response beat structures exchanged with the core/arbiter.
package cbus_resp_pkg;

  localparam int BEAT_CNT_W = 4;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} resp_state_t;

  // Request beat: len is beats-1, data/strobe change per beat on writes.
  typedef struct packed {
    logic                  valid;
    logic                  is_write;
    logic [1:0]            size;
    logic [31:0]           addr;
    logic [3:0]            strobe;
    logic [31:0]           data;
    logic [BEAT_CNT_W-1:0] len;
  } cbus_req_t;

  // Response beat: one ready pulse per transferred word.
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_stall_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) producing a pseudo-random stall
// bit. Only instantiated when CBUS_SRAM_RANDOM_STALL_EN is defined.
module cbus_stall_lfsr (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic        stall
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign stall = lfsr_q[0];

  // Free-running shift register, reloaded with the seed on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= seed;
    else       lfsr_q <= {lfsr_q[14:0], fb};
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus target backed by an inline word-addressed register RAM. Handles single
// beats and INCR bursts (1..16 beats), reads and byte-strobed writes, with a
// fixed LATENCY between acceptance and the first beat.
// Optional macro CBUS_SRAM_RANDOM_STALL_EN: withholds ready on pseudo-random
// BURST cycles to exercise master stall handling.
module cbus_sram_responder
  import cbus_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  resp_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;
  logic                  wr_q, wr_d;
  logic                  ready_q, ready_d, last_q, last_d;
  logic [31:0]           data_q, data_d;
  logic                  present;
  logic                  stall;

`ifdef CBUS_SRAM_RANDOM_STALL_EN
  cbus_stall_lfsr u_stall (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .stall (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // Address LSBs, size and aliased upper address bits carry no meaning here.
  logic unused_req_bits;
  assign unused_req_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:IDX_W+2]};

  // Next-state and next-beat decode; 'present' means a beat is offered next cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wr_d    = wr_q;
    wcnt_d  = wcnt_q;
    present = 1'b0;
    case (state_q)
      IDLE: begin
        if (creq.valid) begin
          idx_d = creq.addr[2 +: IDX_W];
          wr_d  = creq.is_write;
          len_d = creq.len;
          cnt_d = '0;
          if (LATENCY == 0) begin
            state_d = BURST;
            present = 1'b1;
          end else begin
            // WAIT is held for LATENCY cycles, counting down to zero.
            state_d = WAIT;
            wcnt_d  = WAIT_CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (!creq.valid) begin
          state_d = IDLE;
        end else if (wcnt_q == '0) begin
          state_d = BURST;
          present = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      BURST: begin
        if (!creq.valid) begin
          state_d = IDLE;
        end else if (ready_q) begin
          if (cnt_q == len_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            present = 1'b1;
          end
        end else begin
          // Stalled beat: retry the same index/count.
          present = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = present && !stall;
    last_d  = ready_d && (cnt_d == len_d);
    data_d  = (ready_d && !wr_d) ? mem[idx_d] : '0;
  end

  // Control state and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      wcnt_q  <= '0;
      ready_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Byte-strobed RAM write on each accepted write beat; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == BURST && ready_q && wr_q && creq.valid) begin
      for (int j = 0; j < 4; j++) begin
        if (creq.strobe[j]) mem[idx_q][8*j +: 8] <= creq.data[8*j +: 8];
      end
    end
  end

  assign cresp = '{ready: ready_q, last: last_q, data: data_q};
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Scoreboard bench for cbus_sram_responder: a driver issues transactions and
// pushes expected beats; a negedge monitor pops and compares each ready beat.
module tb_cbus_sram_responder;
  import cbus_resp_pkg::*;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       busy;

  always #5 clk = ~clk;

  cbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .LFSR_SEED(16'hACE1)) dut (
    .clk   (clk),
    .reset (reset),
    .creq  (creq),
    .cresp (cresp),
    .busy  (busy)
  );

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        last;
    int          exp_cyc;
  } exp_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mdl [DEPTH];
  logic [31:0] tx_data [16];
  logic [3:0]  tx_strb [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (!cresp.ready) begin
        chk("idle_out", {31'd0, cresp.last, cresp.data}, 64'd0);
      end else if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %h last %0d expected no beat", cresp.data, cresp.last);
      end else begin
        mon_e = sbq.pop_front();
        chk("last", {63'd0, cresp.last}, {63'd0, mon_e.last});
        if (!mon_e.wr) chk("rdata", {32'd0, cresp.data}, {32'd0, mon_e.data});
`ifndef CBUS_SRAM_RANDOM_STALL_EN
        chk("beat_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
`endif
      end
    end
  end

  // One transaction. cut_kind: 0 none, 1 reset pulse, 2 drop valid, applied
  // while beat cut_after is being presented. hold keeps valid high one cycle past the end.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input int len,
                        input int cut_after, input int cut_kind, input bit hold);
    int   base;
    int   done;
    int   budget;
    bit   prev;
    exp_t e;
    base = int'((addr >> 2) % DEPTH);
    done = 0;
    budget = 0;
    prev = 1'b0;
    chk("busy_before", {63'd0, busy}, 64'd0);
    for (int k = 0; k <= len; k++) begin
      e.wr = wr;
      e.last = (k == len);
      e.data = wr ? 32'd0 : mdl[(base + k) % DEPTH];
      e.exp_cyc = cyc + 1 + LAT + k;
      sbq.push_back(e);
    end
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.addr     = addr;
    creq.len      = 4'(len);
    creq.size     = 2'($urandom);
    creq.data     = tx_data[0];
    creq.strobe   = tx_strb[0];
    while (done <= len) begin
      @(negedge clk);
      budget++;
      if (prev) begin
        if (wr) begin
          for (int j = 0; j < 4; j++)
            if (tx_strb[done][j]) mdl[(base + done) % DEPTH][8*j +: 8] = tx_data[done][8*j +: 8];
        end
        done++;
        if (done <= len) begin
          creq.data   = tx_data[done];
          creq.strobe = tx_strb[done];
        end
      end
      prev = cresp.ready;
      if (cut_kind != 0 && done == cut_after) begin
        #2;
        if (cut_kind == 1) begin
          reset = 1'b1;
          #1;
          chk("rst_ready", {63'd0, cresp.ready}, 64'd0);
          chk("rst_busy", {63'd0, busy}, 64'd0);
        end
        creq.valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("cut_idle", {63'd0, busy}, 64'd0);
        return;
      end
      if (budget > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL txn_timeout: got %0d beats expected %0d", done, len + 1);
        sbq.delete();
        creq.valid = 1'b0;
        return;
      end
    end
    if (!hold) creq.valid = 1'b0;
    @(negedge clk);
    creq.valid = 1'b0;
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
  endtask

  task automatic fill(input bit rnd, input logic [31:0] val, input logic [3:0] strb);
    for (int k = 0; k < 16; k++) begin
      tx_data[k] = rnd ? $urandom : val + 32'(k);
      tx_strb[k] = rnd ? 4'($urandom) : strb;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    creq  = '0;
    fill(0, 32'd0, 4'hF);
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'd0, cresp.ready}, 64'd0);
    chk("reset_last", {63'd0, cresp.last}, 64'd0);
    chk("reset_data", {32'd0, cresp.data}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Give every word a known value.
    for (int b = 0; b < DEPTH / 16; b++) begin
      for (int k = 0; k < 16; k++) begin tx_data[k] = $urandom; tx_strb[k] = 4'hF; end
      do_txn(1'b1, 32'(b * 64), 15, -1, 0, 1'b0);
    end

    // 16-beat write of beat numbers, then 16-beat read.
    fill(0, 32'd0, 4'hF);
    do_txn(1'b1, 32'h0, 15, -1, 0, 1'b0);
    do_txn(1'b0, 32'h0, 15, -1, 0, 1'b0);

    // Single write/read.
    tx_data[0] = 32'hDEADBEEF; tx_strb[0] = 4'hF;
    do_txn(1'b1, 32'h10, 0, -1, 0, 1'b0);
    do_txn(1'b0, 32'h10, 0, -1, 0, 1'b0);

    // Partial strobe merge: expect FF22FF44.
    tx_data[0] = 32'hFFFFFFFF; tx_strb[0] = 4'hF;
    do_txn(1'b1, 32'h20, 0, -1, 0, 1'b0);
    tx_data[0] = 32'h11223344; tx_strb[0] = 4'b0101;
    do_txn(1'b1, 32'h20, 0, -1, 0, 1'b0);
    do_txn(1'b0, 32'h20, 0, -1, 0, 1'b0);

    // Wrapping read with aliased upper address bits.
    do_txn(1'b0, 32'hA000_0000 | 32'((DEPTH - 2) * 4), 3, -1, 0, 1'b0);

    // Valid held past last: DONE must not re-accept.
    fill(1, 32'd0, 4'hF);
    do_txn(1'b1, 32'(30 * 4), 3, -1, 0, 1'b1);
    do_txn(1'b0, 32'(30 * 4), 3, -1, 0, 1'b1);

    // Reset mid write burst: beats 0..2 kept, rest untouched.
    fill(1, 32'd0, 4'hF);
    do_txn(1'b1, 32'(40 * 4), 7, 3, 1, 1'b0);
    do_txn(1'b0, 32'(38 * 4), 11, -1, 0, 1'b0);

    // Valid dropped mid write burst: no further writes.
    fill(1, 32'd0, 4'hF);
    do_txn(1'b1, 32'(20 * 4), 5, 2, 2, 1'b0);
    do_txn(1'b0, 32'(18 * 4), 9, -1, 0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      fill(1, 32'd0, 4'hF);
      do_txn(1'($urandom), $urandom, int'($urandom_range(0, 15)), -1, 0, 1'b0);
    end

    // Eight-beat read (gapped when stalls are enabled).
    do_txn(1'b0, 32'h0, 7, -1, 0, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
